// File: rtl/decode_stage_pipe.sv
// RISC-V decode stage with register file, load-use hazard detection and the ID/EX register.
// Optional macro WB_BYPASS_EN: same-cycle write-back data is forwarded into rd1_e/rd2_e.
module decode_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int RADDR_W = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_d,
    input  logic [31:0]        instr_d,
    input  logic [XLEN-1:0]    pc_d,
    input  logic [XLEN-1:0]    pc_plus4_d,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               hazard_o,
    output logic               valid_e,
    output logic [20:0]        ctrl_e,
    output logic [XLEN-1:0]    rd1_e,
    output logic [XLEN-1:0]    rd2_e,
    output logic [XLEN-1:0]    imm_e,
    output logic [XLEN-1:0]    pc_e,
    output logic [XLEN-1:0]    pc_plus4_e,
    output logic [RADDR_W-1:0] rs1_e,
    output logic [RADDR_W-1:0] rs2_e,
    output logic [RADDR_W-1:0] rd_e
);

    typedef struct packed {
        logic               valid;
        logic [20:0]        ctrl;
        logic [XLEN-1:0]    rd1;
        logic [XLEN-1:0]    rd2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc4;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
    } idex_t;

    idex_t                          idex, dec;
    logic [NREGS-1:0][XLEN-1:0]     regs;
    logic [RADDR_W-1:0]             rs1, rs2, rd;
    logic [20:0]                    ctrl_dec;
    logic [XLEN-1:0]                imm_dec, rf1, rf2;
    logic                           ld_use;

    assign rs1 = instr_d[15 +: RADDR_W];
    assign rs2 = instr_d[20 +: RADDR_W];
    assign rd  = instr_d[7  +: RADDR_W];

    ControlUnit u_ctrl (
        .op       (instr_d[6:0]),
        .funct3   (instr_d[14:12]),
        .funct7b5 (instr_d[30]),
        .ctrl     (ctrl_dec)
    );

    ImmediateExtension #(.XLEN(XLEN)) u_imm (
        .instr (instr_d),
        .imm   (imm_dec)
    );

    // x0 is never written, so its flops stay at their reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs <= '0;
        else if (wb_we && wb_rd != '0)
            regs[wb_rd] <= wb_data;
    end

`ifdef WB_BYPASS_EN
    assign rf1 = (wb_we && wb_rd != '0 && wb_rd == rs1) ? wb_data : regs[rs1];
    assign rf2 = (wb_we && wb_rd != '0 && wb_rd == rs2) ? wb_data : regs[rs2];
`else
    assign rf1 = regs[rs1];
    assign rf2 = regs[rs2];
`endif

    // ResultSrc == 01 marks a load in EX
    assign ld_use = valid_d && idex.valid && (idex.ctrl[19:18] == 2'b01) &&
                    (idex.rd != '0) && ((idex.rd == rs1) || (idex.rd == rs2));
    assign hazard_o = ld_use && !rst;

    always_comb begin
        dec       = '0;
        dec.valid = valid_d;
        dec.ctrl  = valid_d ? ctrl_dec : '0;
        dec.rd1   = rf1;
        dec.rd2   = rf2;
        dec.imm   = imm_dec;
        dec.pc    = pc_d;
        dec.pc4   = pc_plus4_d;
        dec.rs1   = rs1;
        dec.rs2   = rs2;
        dec.rd    = rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idex <= '0;
        else if (flush_i)
            idex <= '0;
        else if (!stall_i)
            idex <= ld_use ? '0 : dec;
    end

    assign valid_e    = idex.valid;
    assign ctrl_e     = idex.ctrl;
    assign rd1_e      = idex.rd1;
    assign rd2_e      = idex.rd2;
    assign imm_e      = idex.imm;
    assign pc_e       = idex.pc;
    assign pc_plus4_e = idex.pc4;
    assign rs1_e      = idex.rs1;
    assign rs2_e      = idex.rs2;
    assign rd_e       = idex.rd;

endmodule

// Main decoder: ctrl = {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc,
// ALUControl, StoreSrc, TypeBranch, LoadSrc, ALUSrcA, SumSrc}.
module ControlUnit (
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [20:0] ctrl
);
    logic       reg_write, mem_write, jump, branch, alu_src, alu_src_a, sum_src;
    logic [1:0] result_src, store_src;
    logic [3:0] alu_control;
    logic [2:0] type_branch, load_src;

    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_src     = 1'b0;
        alu_src_a   = 1'b0;
        sum_src     = 1'b0;
        result_src  = 2'b00;
        store_src   = 2'b00;
        alu_control = 4'b0000;
        type_branch = 3'b000;
        load_src    = 3'b000;
        case (op)
            7'b0110011: begin
                reg_write   = 1'b1;
                alu_control = {funct7b5, funct3};
            end
            7'b0010011: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = {(funct3 == 3'b101) & funct7b5, funct3};
            end
            7'b0000011: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                alu_src    = 1'b1;
                load_src   = funct3;
            end
            7'b0100011: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                store_src = funct3[1:0];
            end
            7'b1100011: begin
                branch      = 1'b1;
                alu_control = 4'b1000;
                type_branch = funct3;
            end
            7'b1101111: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            7'b1100111: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                jump       = 1'b1;
                alu_src    = 1'b1;
                sum_src    = 1'b1;
            end
            7'b0110111: begin
                reg_write  = 1'b1;
                result_src = 2'b11;
                alu_src    = 1'b1;
            end
            7'b0010111: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_src_a = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl = {reg_write, result_src, mem_write, jump, branch, alu_src,
                   alu_control, store_src, type_branch, load_src, alu_src_a, sum_src};
endmodule

// Immediate generator for I/S/B/U/J formats, sign-extended to XLEN.
module ImmediateExtension #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            7'b0100011:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {instr[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: ;
        endcase
    end

    assign imm = XLEN'($signed(imm32));
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe; expected values are hand-computed from the encodings.
module tb_decode_stage_pipe;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [31:0] ADDI_X5  = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] ADD_X6   = 32'h0031_8333; // add  x6,x3,x3
    localparam logic [31:0] LW_X7    = 32'h0000_A383; // lw   x7,0(x1)
    localparam logic [31:0] ADD_X8   = 32'h0023_8433; // add  x8,x7,x2
    localparam logic [31:0] ADD_X9   = 32'h0000_04B3; // add  x9,x0,x0

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_d;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d, pc_plus4_d;
    logic            stall_i, flush_i;
    logic            wb_we;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            hazard_o, valid_e;
    logic [20:0]     ctrl_e;
    logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
    logic [RW-1:0]   rs1_e, rs2_e, rd_e;

    int n_chk  = 0;
    int n_fail = 0;

    decode_stage_pipe dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .stall_i(stall_i), .flush_i(flush_i),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .hazard_o(hazard_o),
        .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        valid_d    = 1'b1;
        instr_d    = ins;
        pc_d       = pc;
        pc_plus4_d = pc + 4;
    endtask

    initial begin
        rst = 1'b1; valid_d = 1'b1; instr_d = ADD_X8; pc_d = '0; pc_plus4_d = '0;
        stall_i = 1'b0; flush_i = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        step(); step();
        chk("rst_valid", valid_e, 0);
        chk("rst_ctrl",  ctrl_e, 0);
        chk("rst_pc",    pc_e, 0);
        chk("rst_haz",   hazard_o, 0);
        rst = 1'b0;

        // 1: addi x5,x0,7
        dec(ADDI_X5, 32'h100);
        step();
        chk("addi_valid", valid_e, 1);
        chk("addi_rd",    rd_e, 5);
        chk("addi_imm",   imm_e, 7);
        chk("addi_regw",  ctrl_e[20], 1);
        chk("addi_alusrc", ctrl_e[14], 1);
        chk("addi_mw_j_b", ctrl_e[17:15], 0);
        chk("addi_pc",    pc_e, 32'h100);
        chk("addi_pc4",   pc_plus4_e, 32'h104);

        // 2: write x3, then read it twice
        wb_we = 1'b1; wb_rd = 3; wb_data = 32'hDEADBEEF;
        dec(ADDI_X5, 32'h104);
        step();
        wb_we = 1'b0;
        dec(ADD_X6, 32'h108);
        step();
        chk("wb_rd1", rd1_e, 32'hDEADBEEF);
        chk("wb_rd2", rd2_e, 32'hDEADBEEF);
        chk("wb_rs1", rs1_e, 3);
        chk("wb_rs2", rs2_e, 3);
        chk("wb_rdidx", rd_e, 6);

        // 3: write and read x3 in the same cycle
        wb_we = 1'b1; wb_rd = 3; wb_data = 32'h55;
        step();
`ifdef WB_BYPASS_EN
        chk("byp_rd1", rd1_e, 32'h55);
`else
        chk("byp_rd1", rd1_e, 32'hDEADBEEF);
`endif
        wb_we = 1'b0;
        step();
        chk("byp_after", rd1_e, 32'h55);

        // 4: load-use
        dec(LW_X7, 32'h200);
        step();
        chk("lw_valid", valid_e, 1);
        chk("lw_rsrc",  ctrl_e[19:18], 2'b01);
        chk("lw_rd",    rd_e, 7);
        dec(ADD_X8, 32'h204);
        #1;
        chk("lu_haz", hazard_o, 1);
        step();
        chk("lu_bub_valid", valid_e, 0);
        chk("lu_bub_ctrl",  ctrl_e, 0);
        chk("lu_haz_clr",   hazard_o, 0);
        step();
        chk("lu_add_valid", valid_e, 1);
        chk("lu_add_rd",    rd_e, 8);
        chk("lu_add_pc",    pc_e, 32'h204);
        chk("lu_add_regw",  ctrl_e[20], 1);

        // 5: stall holds, flush beats stall
        stall_i = 1'b1;
        dec(ADDI_X5, 32'h300); step();
        chk("st1_rd", rd_e, 8);
        dec(LW_X7, 32'h304); step();
        chk("st2_pc", pc_e, 32'h204);
        dec(ADD_X6, 32'h308); step();
        chk("st3_rd",    rd_e, 8);
        chk("st3_valid", valid_e, 1);
        chk("st3_rs1",   rs1_e, 7);
        flush_i = 1'b1;
        step();
        chk("fl_valid", valid_e, 0);
        chk("fl_ctrl",  ctrl_e, 0);
        flush_i = 1'b0; stall_i = 1'b0;

        // valid_d low loads a bubble
        dec(ADDI_X5, 32'h400); valid_d = 1'b0;
        step();
        chk("vd0_valid", valid_e, 0);
        chk("vd0_ctrl",  ctrl_e, 0);

        // 6: writes to x0 dropped
        wb_we = 1'b1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        dec(ADD_X9, 32'h500);
        step();
        chk("x0_same", rd1_e, 0);
        wb_we = 1'b0;
        step();
        chk("x0_rd1",   rd1_e, 0);
        chk("x0_rd2",   rd2_e, 0);
        chk("x0_valid", valid_e, 1);

        // asynchronous reset during a stall
        stall_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid_e, 0);
        chk("arst_rd",    rd_e, 0);
        chk("arst_haz",   hazard_o, 0);
        stall_i = 1'b0;
        #1 rst = 1'b0;
        dec(ADD_X6, 32'h600);
        step();
        chk("post_valid", valid_e, 1);
        chk("post_rf",    rd1_e, 0);
        chk("post_pc",    pc_e, 32'h600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised RISC-V decode stage with an integrated ID/EX pipeline register.
- Instantiates the existing ControlUnit and ImmediateExtension and contains an XLEN x NREGS register file.
- Adds write-back bypass, load-use hazard detection, stall/flush handling and a valid bit.
- Sits between the IF/ID register and the execute stage; every output except hazard_o is registered.

Parameters:
- XLEN, 32, data and PC width.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2.
- RADDR_W, $clog2(NREGS), register index width.

Ports:
- clk  input  1  stage clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_d  input  1  the IF/ID register holds a real instruction.
- instr_d  input  32  instruction word.
- pc_d  input  XLEN  PC of the instruction.
- pc_plus4_d  input  XLEN  PC+4 of the instruction.
- stall_i  input  1  downstream stall; the ID/EX register holds its contents.
- flush_i  input  1  branch/jump redirect; the ID/EX register is loaded with a bubble.
- wb_we  input  1  write-back enable.
- wb_rd  input  RADDR_W  write-back destination register.
- wb_data  input  XLEN  write-back data.
- hazard_o  output  1  combinational load-use stall request to fetch and IF/ID.
- valid_e  output  1  the ID/EX register holds a real instruction.
- ctrl_e  output  21  control bundle, MSB to LSB: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl[3:0], StoreSrc[1:0], TypeBranch[2:0], LoadSrc[2:0], ALUSrcA, SumSrc.
- rd1_e  output  XLEN  rs1 operand.
- rd2_e  output  XLEN  rs2 operand.
- imm_e  output  XLEN  extended immediate.
- pc_e  output  XLEN  registered PC.
- pc_plus4_e  output  XLEN  registered PC+4.
- rs1_e  output  RADDR_W  rs1 index (instr[19:15], low RADDR_W bits).
- rs2_e  output  RADDR_W  rs2 index (instr[24:20], low RADDR_W bits).
- rd_e  output  RADDR_W  rd index (instr[11:7], low RADDR_W bits).

Behaviour:
- Reset, asynchronous on the rising edge of rst:
  - all ID/EX outputs are 0 and valid_e is 0;
  - all registers in the file are 0;
  - hazard_o = 0 while rst is high.
- Register file:
  - writes on the rising edge of clk when wb_we = 1 and wb_rd != 0;
  - register 0 is hard-wired to 0, and writes to it are dropped;
  - reads are combinational.
- Load-use hazard: hazard_o = valid_d & valid_e & (ctrl_e ResultSrc == 2'b01) & (rd_e != 0) & ((rd_e == rs1) | (rd_e == rs2)), where rs1/rs2 are the indices of the current instr_d.
- ID/EX update on each clk edge, in priority order:
  1. flush_i: load a bubble.
  2. stall_i: hold all contents.
  3. hazard_o: load a bubble.
  4. Otherwise: load the decoded instr_d.
- Bubble definition: valid_e = 0 and ctrl_e = 0 (no RegWrite, MemWrite, Branch or Jump). Data fields are don't-care; the RTL zeroes them.
- A normal load with valid_d = 0 also forces ctrl_e = 0 and valid_e = 0.
- Latency: one cycle from instr_d to the _e outputs.
- A flush asserted in the same cycle as a hazard wins. hazard_o still asserts combinationally; fetch discards it because it is also redirecting.
- Reset asserted mid-stall clears everything immediately; the first post-reset edge with no stall loads normally.
- Unknown opcodes decode to whatever ControlUnit produces; this block adds no illegal-instruction trap.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-first bypass. If wb_we = 1, wb_rd != 0 and wb_rd equals rs1 (or rs2), then rd1_e (or rd2_e) loads wb_data in the same cycle instead of the stale file value.
- Not defined: the register file returns the pre-write value. The hazard unit elsewhere must then cover the W-to-D distance.
- Both builds must pass every test below except test 3, which has one expected value per build.

Test Plan:
1. Reset, then release; present addi x5,x0,7 (0x00700293) with valid_d = 1 -> next cycle: valid_e = 1, rd_e = 5, imm_e = 7, RegWrite = 1, ALUSrc = 1.
2. Write-back x3 = 0xDEADBEEF, then decode add x6,x3,x3 -> rd1_e = rd2_e = 0xDEADBEEF.
3. Same cycle: wb_we = 1, wb_rd = 3, wb_data = 0x55, with instr_d reading x3:
   - WB_BYPASS_EN defined -> rd1_e = 0x55;
   - not defined -> rd1_e holds the old value.
4. lw x7,0(x1) in ID/EX with add x8,x7,x2 in decode -> hazard_o = 1. Next edge: valid_e = 0, ctrl_e = 0. Following cycle: hazard_o = 0 and the add loads.
5. stall_i = 1 for 3 cycles with the instruction changing -> _e outputs stay constant. Then flush_i = 1 together with stall_i = 1 -> bubble loaded.
6. wb_we = 1, wb_rd = 0, wb_data = 0xFFFFFFFF, then decode a read of x0 -> rd1_e = 0. Assert rst mid-stream -> valid_e drops to 0 without waiting for a clock edge.
